register_file_param: RTL and testbench

Parametrised, scoreboarded successor to the MiniComputer's 32×32 register file. It has three combinational read ports (A, B, Client) with same-cycle write forwarding and an optional hardwired-zero register 0. It keeps a per-register pending bit so the control unit can stall on outstanding writes. After reset, it clears its storage sequentially through a small state machine, which lets the array map onto RAM. It sits between the datapath ALU/writeback stage and the control unit.

---
 rtl/register_file_param.sv | 75 +++++++
 tb/tb_register_file_param.sv | 139 +++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// register_file_param: 3-read/1-write register file with per-register pending bits,
// same-cycle write forwarding and a post-reset sequential clear (RAM-friendly array).
module register_file_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              Clk_i,
   input  logic              Rst_i,
   input  logic              WRF_i,
   input  logic [ADDR_W-1:0] WriteAddr_i,
   input  logic [DATA_W-1:0] WriteData_i,
   input  logic              RsvEn_i,
   input  logic [ADDR_W-1:0] RsvAddr_i,
   input  logic [ADDR_W-1:0] AAddr_i,
   input  logic [ADDR_W-1:0] BAddr_i,
   input  logic [ADDR_W-1:0] ClientAddr_i,
   output logic [DATA_W-1:0] AData_o,
   output logic [DATA_W-1:0] BData_o,
   output logic [DATA_W-1:0] ClientData_o,
   output logic              APending_o,
   output logic              BPending_o,
   output logic              ClientPending_o,
   output logic              Busy_o
);
   localparam int DEPTH = 2**ADDR_W;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic              busy, we, rv;
   logic [ADDR_W-1:0] raddr [3];
   logic [DATA_W-1:0] rdata [3];
   logic              rpend [3];
   assign busy = Rst_i || state_q == CLEAR;
   assign we   = WRF_i && !busy && !(ZERO_REG && WriteAddr_i == '0);
   assign rv   = RsvEn_i && !busy && !(ZERO_REG && RsvAddr_i == '0);
   always_ff @(posedge Clk_i)
      if (Rst_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else if (state_q == CLEAR) begin
         cnt_q <= cnt_q + 1'b1;
         if (&cnt_q) state_q <= RUN;
      end
   // Storage has no reset so it can map onto RAM; the clear walk zeroes it instead.
   always_ff @(posedge Clk_i)
      if (state_q == CLEAR) mem_q[cnt_q] <= '0;
      else if (we) mem_q[WriteAddr_i] <= WriteData_i;
   // Reserve is applied last so it wins over a same-address write.
   always_ff @(posedge Clk_i)
      if (state_q == CLEAR) pend_q[cnt_q] <= 1'b0;
      else begin
         if (we) pend_q[WriteAddr_i] <= 1'b0;
         if (rv) pend_q[RsvAddr_i] <= 1'b1;
      end
   assign raddr[0] = AAddr_i;
   assign raddr[1] = BAddr_i;
   assign raddr[2] = ClientAddr_i;
   for (genvar i = 0; i < 3; i++) begin : g_rd
      logic zero, fwd;
      assign zero     = busy || (ZERO_REG && raddr[i] == '0);
      assign fwd      = WRF_i && raddr[i] == WriteAddr_i;
      assign rdata[i] = zero ? '0 : fwd ? WriteData_i : mem_q[raddr[i]];
      assign rpend[i] = !zero && !fwd && pend_q[raddr[i]];
   end
   assign AData_o         = rdata[0];
   assign BData_o         = rdata[1];
   assign ClientData_o    = rdata[2];
   assign APending_o      = rpend[0];
   assign BPending_o      = rpend[1];
   assign ClientPending_o = rpend[2];
   assign Busy_o          = busy;
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: vector table + scoreboard queue for the default instance,
// hand sequences for reset corners and a DATA_W=16/ADDR_W=3/ZERO_REG=0 instance.
module tb_register_file_param;
   typedef struct {
      logic        rst, wrf, rsv;
      logic [4:0]  wa, ra, aa, ba, ca;
      logic [31:0] wd, ea, eb, ec;
      logic        eap, ebp, ecp, ebusy;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst, wrf, rsv;
   logic [4:0]  wa, ra, aa, ba, ca;
   logic [31:0] wd, ad, bd, cd;
   logic        ap, bp, cp, busy;
   logic        s_rst, s_wrf, s_rsv;
   logic [2:0]  s_wa, s_ra, s_aa, s_ba, s_ca;
   logic [15:0] s_wd, s_ad, s_bd, s_cd;
   logic        s_ap, s_bp, s_cp, s_busy;
   int total = 0, bad = 0, step = 0;
   vec_t exp_q[$];
   vec_t tbl[17];
   always #5 clk = ~clk;
   register_file_param dut (
      .Clk_i(clk), .Rst_i(rst), .WRF_i(wrf), .WriteAddr_i(wa), .WriteData_i(wd),
      .RsvEn_i(rsv), .RsvAddr_i(ra), .AAddr_i(aa), .BAddr_i(ba), .ClientAddr_i(ca),
      .AData_o(ad), .BData_o(bd), .ClientData_o(cd),
      .APending_o(ap), .BPending_o(bp), .ClientPending_o(cp), .Busy_o(busy)
   );
   register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut_s (
      .Clk_i(clk), .Rst_i(s_rst), .WRF_i(s_wrf), .WriteAddr_i(s_wa), .WriteData_i(s_wd),
      .RsvEn_i(s_rsv), .RsvAddr_i(s_ra), .AAddr_i(s_aa), .BAddr_i(s_ba), .ClientAddr_i(s_ca),
      .AData_o(s_ad), .BData_o(s_bd), .ClientData_o(s_cd),
      .APending_o(s_ap), .BPending_o(s_bp), .ClientPending_o(s_cp), .Busy_o(s_busy)
   );
   function automatic vec_t mk(int r, int w, int wadr, int wdat, int rs, int radr,
                               int a, int b, int c, int xa, int xap, int xb, int xbp,
                               int xc, int xcp, int xbusy);
      vec_t v;
      v.rst = r != 0; v.wrf = w != 0; v.rsv = rs != 0;
      v.wa = 5'(wadr); v.ra = 5'(radr); v.aa = 5'(a); v.ba = 5'(b); v.ca = 5'(c);
      v.wd = 32'(wdat); v.ea = 32'(xa); v.eb = 32'(xb); v.ec = 32'(xc);
      v.eap = xap != 0; v.ebp = xbp != 0; v.ecp = xcp != 0; v.ebusy = xbusy != 0;
      return v;
   endfunction
   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL step %0d %s: got %h expected %h", step, name, got, exp);
      end
   endtask
   task automatic apply(vec_t v);
      vec_t e;
      rst = v.rst; wrf = v.wrf; wa = v.wa; wd = v.wd; rsv = v.rsv; ra = v.ra;
      aa = v.aa; ba = v.ba; ca = v.ca;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check("AData", ad, e.ea);
      check("APending", 32'(ap), 32'(e.eap));
      check("BData", bd, e.eb);
      check("BPending", 32'(bp), 32'(e.ebp));
      check("ClientData", cd, e.ec);
      check("ClientPending", 32'(cp), 32'(e.ecp));
      check("Busy", 32'(busy), 32'(e.ebusy));
      step++;
      @(posedge clk);
      #1;
   endtask
   task automatic clear_run(int n);
      for (int k = 0; k < n; k++) apply(mk(0, 0, 0, 0, 0, 0, 2, 4, 7, 0, 0, 0, 0, 0, 0, 1));
   endtask
   initial begin
      tbl[0]  = mk(0, 0, 0, 0,      0, 0,  3, 3, 3,  0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 5, 'h9A,   0, 0,  3, 1, 5,  0, 0, 0, 0, 'h9A, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,      0, 0,  3, 1, 5,  0, 0, 0, 0, 'h9A, 0, 0);
      tbl[3]  = mk(0, 1, 0, 'hFE,   1, 0,  0, 5, 0,  0, 0, 'h9A, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0,      0, 0,  0, 5, 0,  0, 0, 'h9A, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0,      1, 7,  7, 5, 0,  0, 0, 'h9A, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0,      0, 0,  7, 5, 0,  0, 1, 'h9A, 0, 0, 0, 0);
      tbl[7]  = mk(0, 1, 7, 'hD8,   0, 0,  7, 5, 0,  'hD8, 0, 'h9A, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0,      0, 0,  7, 5, 0,  'hD8, 0, 'h9A, 0, 0, 0, 0);
      tbl[9]  = mk(0, 1, 7, 'hD8,   1, 7,  7, 5, 0,  'hD8, 0, 'h9A, 0, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0,      0, 0,  7, 5, 0,  'hD8, 1, 'h9A, 0, 0, 0, 0);
      tbl[11] = mk(0, 1, 9, 'h1234, 1, 10, 9, 10, 7, 'h1234, 0, 0, 0, 'hD8, 1, 0);
      tbl[12] = mk(0, 0, 0, 0,      0, 0,  9, 10, 9, 'h1234, 0, 0, 1, 'h1234, 0, 0);
      tbl[13] = mk(0, 0, 0, 0,      0, 0,  7, 7, 7,  'hD8, 1, 'hD8, 1, 'hD8, 1, 0);
      tbl[14] = mk(0, 1, 2, 'h11,   1, 4,  2, 4, 2,  'h11, 0, 0, 0, 'h11, 0, 0);
      tbl[15] = mk(0, 0, 0, 0,      0, 0,  2, 4, 7,  'h11, 0, 0, 1, 'hD8, 1, 0);
      tbl[16] = mk(1, 0, 0, 0,      0, 0,  2, 4, 7,  0, 0, 0, 0, 0, 0, 1);
      {rst, wrf, rsv} = 3'b100; {wa, ra, aa, ba, ca} = '0; wd = '0;
      {s_rst, s_wrf, s_rsv} = 3'b100; {s_wa, s_ra, s_aa, s_ba, s_ca} = '0; s_wd = '0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) apply(mk(1, 0, 0, 0, 0, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 1));
      // Clear walk: a write and a reserve to reg 3 land mid-clear and must be dropped.
      for (int k = 0; k < 32; k++)
         apply(mk(0, k == 5 ? 1 : 0, 3, 'hAA, k == 6 ? 1 : 0, 3, 3, 5, 3, 0, 0, 0, 0, 0, 0, 1));
      foreach (tbl[k]) apply(tbl[k]);
      clear_run(32);
      apply(mk(0, 0, 0, 0, 0, 0, 2, 4, 7, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, 1, 2, 'h11, 1, 4, 2, 4, 2, 'h11, 0, 0, 0, 'h11, 0, 0));
      apply(mk(1, 0, 0, 0, 0, 0, 2, 4, 7, 0, 0, 0, 0, 0, 0, 1));
      clear_run(10);
      apply(mk(1, 0, 0, 0, 0, 0, 2, 4, 7, 0, 0, 0, 0, 0, 0, 1));
      clear_run(32);
      apply(mk(0, 0, 0, 0, 0, 0, 2, 4, 2, 0, 0, 0, 0, 0, 0, 0));
      if (exp_q.size() != 0) check("scoreboard drained", 32'(exp_q.size()), 0);
      s_rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("s Busy clear", 32'(s_busy), 1);
         check("s AData clear", 32'(s_ad), 0);
         @(posedge clk);
         #1;
      end
      s_wrf = 1'b1; s_wa = 3'd0; s_wd = 16'hBEEF; s_aa = 3'd0; s_ba = 3'd1;
      @(negedge clk);
      check("s Busy run", 32'(s_busy), 0);
      check("s AData fwd", 32'(s_ad), 32'hBEEF);
      check("s BData", 32'(s_bd), 0);
      @(posedge clk);
      #1;
      s_wrf = 1'b0; s_rsv = 1'b1; s_ra = 3'd0; s_ba = 3'd0; s_ca = 3'd0;
      @(negedge clk);
      check("s AData", 32'(s_ad), 32'hBEEF);
      check("s BData", 32'(s_bd), 32'hBEEF);
      check("s ClientData", 32'(s_cd), 32'hBEEF);
      check("s APending pre", 32'(s_ap), 0);
      @(posedge clk);
      #1;
      s_rsv = 1'b0;
      @(negedge clk);
      check("s APending", 32'(s_ap), 1);
      check("s ClientPending", 32'(s_cp), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
